// File: rtl/dotmatrix_scan_capture.sv
// Receive-side monitor for a row-scanned LED dot-matrix bus: follows the row
// sequence, flags scan breaks and rebuilds complete frames into a shadow buffer.
module dotmatrix_scan_capture #(
   parameter  int ROWS  = 16,
   parameter  int COLS  = 16,
   parameter  int CNT_W = 8,
   localparam int SEL_W = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] sel_in,
   input  logic [COLS-1:0]  dot_in,
   input  logic [SEL_W-1:0] rd_row,
   output logic [COLS-1:0]  rd_data,
   output logic             frame_valid,
   output logic             frame_done,
   output logic             frame_changed,
   output logic [CNT_W-1:0] frame_count,
   output logic             seq_err
);

   typedef enum logic {HUNT, CAPTURE} state_t;

   localparam logic [SEL_W-1:0] LAST_ROW = SEL_W'(ROWS - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] exp_q, exp_d;
   logic [COLS-1:0]  cap_q [ROWS];
   logic [COLS-1:0]  cap_d [ROWS];
   logic [COLS-1:0]  shd_q [ROWS];
   logic [COLS-1:0]  shd_d [ROWS];
   logic [COLS-1:0]  new_frame [ROWS];
   logic             frame_diff;

   logic [COLS-1:0]  rd_data_q, rd_data_d;
   logic             frame_valid_q, frame_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_changed_q, frame_changed_d;
   logic [CNT_W-1:0] frame_count_q, frame_count_d;
   logic             seq_err_q, seq_err_d;

   // Candidate frame: rows 0..ROWS-2 already captured, last row straight off the bus.
   always_comb begin
      frame_diff = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         new_frame[r] = (r == ROWS - 1) ? dot_in : cap_q[r];
         frame_diff   = frame_diff | (new_frame[r] != shd_q[r]);
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d         = state_q;
      exp_d           = exp_q;
      cap_d           = cap_q;
      shd_d           = shd_q;
      frame_valid_d   = frame_valid_q;
      frame_count_d   = frame_count_q;
      seq_err_d       = seq_err_q;
      frame_done_d    = 1'b0;
      frame_changed_d = 1'b0;
      rd_data_d       = shd_q[rd_row];

      case (state_q)
         HUNT: begin
            if (sel_in == '0) begin
               cap_d[0] = dot_in;
               exp_d    = SEL_W'(1);
               state_d  = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sel_in == exp_q) begin
               cap_d[exp_q] = dot_in;
               if (exp_q == LAST_ROW) begin
                  exp_d           = '0;
                  shd_d           = new_frame;
                  frame_done_d    = 1'b1;
                  frame_changed_d = frame_diff;
                  frame_count_d   = frame_count_q + CNT_W'(1);
                  frame_valid_d   = 1'b1;
               end else begin
                  exp_d = exp_q + SEL_W'(1);
               end
            end else begin
               // A break discards the partial frame; a row 0 restarts capture at once.
               seq_err_d = 1'b1;
               if (sel_in == '0) begin
                  cap_d[0] = dot_in;
                  exp_d    = SEL_W'(1);
               end else begin
                  exp_d   = '0;
                  state_d = HUNT;
               end
            end
         end
         default: begin
            exp_d   = '0;
            state_d = HUNT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= HUNT;
         exp_q           <= '0;
         rd_data_q       <= '0;
         frame_valid_q   <= 1'b0;
         frame_done_q    <= 1'b0;
         frame_changed_q <= 1'b0;
         frame_count_q   <= '0;
         seq_err_q       <= 1'b0;
         // NOTE: the buffers are cleared on reset because the first commit is
         // compared against an all-zero shadow and reads must return zero.
         for (int r = 0; r < ROWS; r++) begin
            cap_q[r] <= '0;
            shd_q[r] <= '0;
         end
      end else begin
         // NOTE: state updates use non-blocking assignment so every flop samples
         // the pre-edge values regardless of statement order.
         state_q         <= state_d;
         exp_q           <= exp_d;
         rd_data_q       <= rd_data_d;
         frame_valid_q   <= frame_valid_d;
         frame_done_q    <= frame_done_d;
         frame_changed_q <= frame_changed_d;
         frame_count_q   <= frame_count_d;
         seq_err_q       <= seq_err_d;
         cap_q           <= cap_d;
         shd_q           <= shd_d;
      end
   end

   assign rd_data       = rd_data_q;
   assign frame_valid   = frame_valid_q;
   assign frame_done    = frame_done_q;
   assign frame_changed = frame_changed_q;
   assign frame_count   = frame_count_q;
   assign seq_err       = seq_err_q;

endmodule

// File: tb/tb_dotmatrix_scan_capture.sv
// Directed bench for dotmatrix_scan_capture: a vector table for the clean scan
// plus hand-written sequences for breaks, restarts, hunting, reset and wrap.
module tb_dotmatrix_scan_capture;

   logic        clk;
   logic        rst;
   logic [3:0]  sel_in;
   logic [15:0] dot_in;
   logic [3:0]  rd_row;
   logic [15:0] rd_data;
   logic        frame_valid;
   logic        frame_done;
   logic        frame_changed;
   logic [7:0]  frame_count;
   logic        seq_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [3:0]  sel;
      logic [15:0] dot;
      logic [3:0]  rd_row;
      logic        done;
      logic        changed;
      logic [7:0]  count;
      logic        valid;
      logic        err;
      logic [15:0] rd;
   } vec_t;

   vec_t vecs [48];

   dotmatrix_scan_capture #(
      .ROWS (16),
      .COLS (16),
      .CNT_W(8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sel_in       (sel_in),
      .dot_in       (dot_in),
      .rd_row       (rd_row),
      .rd_data      (rd_data),
      .frame_valid  (frame_valid),
      .frame_done   (frame_done),
      .frame_changed(frame_changed),
      .frame_count  (frame_count),
      .seq_err      (seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   task automatic check_flags(input string tag, input logic done, input logic changed,
                              input logic [7:0] count, input logic valid, input logic err);
      check({tag, " frame_done"},    32'(frame_done),    32'(done));
      check({tag, " frame_changed"}, 32'(frame_changed), 32'(changed));
      check({tag, " frame_count"},   32'(frame_count),   32'(count));
      check({tag, " frame_valid"},   32'(frame_valid),   32'(valid));
      check({tag, " seq_err"},       32'(seq_err),       32'(err));
   endtask

   // Present one bus cycle and return 1 time unit after the sampling edge.
   task automatic apply(input logic r, input logic [3:0] s, input logic [15:0] d);
      rst    = r;
      sel_in = s;
      dot_in = d;
      @(posedge clk);
      #1;
   endtask

   // Scan a full frame of rows 0..15: every row carries fill except alt_row.
   task automatic scan_frame(input logic [15:0] fill, input int alt_row,
                             input logic [15:0] alt_val, input bit chk, input string tag);
      for (int r = 0; r < 16; r++) begin
         apply(1'b0, 4'(r), (r == alt_row) ? alt_val : fill);
         if (chk && r < 15)
            check($sformatf("%s row%0d no early done", tag, r), 32'(frame_done), 32'd0);
      end
   endtask

   initial begin
      rst    = 1'b1;
      sel_in = '0;
      dot_in = '0;
      rd_row = '0;

      // Clean scan table: three identical frames, reading row 5 throughout.
      for (int f = 0; f < 3; f++) begin
         for (int r = 0; r < 16; r++) begin
            vec_t v;
            v.sel     = 4'(r);
            v.dot     = 16'(32'h1000 + r);
            v.rd_row  = 4'd5;
            v.done    = (r == 15);
            v.changed = (r == 15) && (f == 0);
            v.count   = 8'(f + ((r == 15) ? 1 : 0));
            v.valid   = (f > 0) || (r == 15);
            v.err     = 1'b0;
            v.rd      = (f == 0) ? 16'h0000 : 16'h1005;
            vecs[f*16 + r] = v;
         end
      end

      // Reset state.
      apply(1'b1, 4'd0, 16'h0);
      apply(1'b1, 4'd0, 16'h0);
      check_flags("reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      check("reset rd_data", 32'(rd_data), 32'h0);

      // Clean scan.
      for (int i = 0; i < 48; i++) begin
         rd_row = vecs[i].rd_row;
         apply(1'b0, vecs[i].sel, vecs[i].dot);
         check_flags($sformatf("clean v%0d", i), vecs[i].done, vecs[i].changed,
                     vecs[i].count, vecs[i].valid, vecs[i].err);
         check($sformatf("clean v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
      end

      // Change detection: blank first frame, A, A, then B with row 8 altered.
      apply(1'b1, 4'd0, 16'h0);
      scan_frame(16'h0000, -1, 16'h0, 1'b1, "blank");
      check_flags("blank commit", 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
      scan_frame(16'h03C0, -1, 16'h0, 1'b1, "A1");
      check_flags("A1 commit", 1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
      scan_frame(16'h03C0, -1, 16'h0, 1'b1, "A2");
      check_flags("A2 commit", 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
      scan_frame(16'h03C0, 8, 16'h3FFC, 1'b1, "B");
      check_flags("B commit", 1'b1, 1'b1, 8'd4, 1'b1, 1'b0);

      // Sequence break: rows 0..6 then 9; broken frame never commits.
      apply(1'b1, 4'd0, 16'h0);
      scan_frame(16'h0F0F, -1, 16'h0, 1'b1, "pre");
      check_flags("pre commit", 1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
      for (int r = 0; r < 7; r++) apply(1'b0, 4'(r), 16'h0A00);
      check_flags("brk row6", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
      apply(1'b0, 4'd9, 16'h0A09);
      check_flags("brk sel9", 1'b0, 1'b0, 8'd1, 1'b1, 1'b1);
      apply(1'b0, 4'd10, 16'h0A0A);
      check_flags("brk hunt", 1'b0, 1'b0, 8'd1, 1'b1, 1'b1);
      scan_frame(16'h00F0, -1, 16'h0, 1'b1, "post");
      check_flags("post commit", 1'b1, 1'b1, 8'd2, 1'b1, 1'b1);

      // Early restart: rows 0..10, then a fresh 0..15 with different data.
      apply(1'b1, 4'd0, 16'h0);
      for (int r = 0; r < 11; r++) apply(1'b0, 4'(r), 16'hAAAA);
      check_flags("early row10", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      for (int r = 0; r < 16; r++) begin
         apply(1'b0, 4'(r), 16'(32'h5500 + r));
         if (r == 0) check("early restart seq_err", 32'(seq_err), 32'd1);
         if (r < 15) check($sformatf("early row%0d no done", r), 32'(frame_done), 32'd0);
      end
      check_flags("early commit", 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
      rd_row = 4'd0;
      apply(1'b0, 4'd7, 16'h0);
      check("early rd row0", 32'(rd_data), 32'h5500);
      rd_row = 4'd10;
      apply(1'b0, 4'd7, 16'h0);
      check("early rd row10", 32'(rd_data), 32'h550A);
      rd_row = 4'd15;
      apply(1'b0, 4'd7, 16'h0);
      check("early rd row15", 32'(rd_data), 32'h550F);

      // Reset at row 9 from a non-idle state; next commit needs a full scan.
      for (int r = 0; r < 9; r++) apply(1'b0, 4'(r), 16'h1234);
      apply(1'b1, 4'd9, 16'h1234);
      check_flags("midrst", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      check("midrst rd_data", 32'(rd_data), 32'h0);
      for (int r = 10; r < 16; r++) begin
         apply(1'b0, 4'(r), 16'h1234);
         check_flags($sformatf("midrst tail row%0d", r), 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      end
      scan_frame(16'h7777, -1, 16'h0, 1'b1, "midrst full");
      check_flags("midrst commit", 1'b1, 1'b1, 8'd1, 1'b1, 1'b0);

      // Hunt entry: scan joins mid-frame at row 7 after reset.
      apply(1'b1, 4'd0, 16'h0);
      for (int r = 7; r < 16; r++) begin
         apply(1'b0, 4'(r), 16'hBEEF);
         check_flags($sformatf("hunt row%0d", r), 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      end
      scan_frame(16'hBEEF, -1, 16'h0, 1'b1, "hunt full");
      check_flags("hunt commit", 1'b1, 1'b1, 8'd1, 1'b1, 1'b0);

      // Counter wrap after 256 clean frames.
      apply(1'b1, 4'd0, 16'h0);
      for (int f = 0; f < 256; f++) begin
         scan_frame((f % 2 == 0) ? 16'h2222 : 16'h1111, -1, 16'h0, 1'b0, "wrap");
         check($sformatf("wrap f%0d frame_done", f), 32'(frame_done), 32'd1);
         check($sformatf("wrap f%0d frame_count", f), 32'(frame_count), 32'((f + 1) % 256));
      end
      check("wrap final frame_count", 32'(frame_count), 32'd0);
      check("wrap final frame_valid", 32'(frame_valid), 32'd1);
      check("wrap final seq_err", 32'(seq_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dotmatrix_scan_capture.md
# dotmatrix_scan_capture

Receive-side monitor for the 16x16 row-scanned LED dot-matrix bus: samples the row-select/row-data pair driven to the panel, checks the scan sequence and rebuilds complete frames into a readable shadow buffer. It sits on the same `sel`/`dot` nets as the panel driver. It is used for on-board self-check and bench scoreboarding, and flags frame completion, glyph changes and scan-sequence errors.

## Interface
- `ROWS`, 16, rows per frame; `sel_in` width is clog2(ROWS).
- `COLS`, 16, bits per row.
- `CNT_W`, 8, width of `frame_count`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sel_in` in 4: row select currently driven to the panel.
- `dot_in` in 16: row pixel data, aligned with `sel_in` in the same cycle.
- `rd_row` in 4: shadow-buffer read address.
- `rd_data` out 16: registered shadow row at `rd_row`.
- `frame_valid` out 1: at least one complete frame has been committed since reset.
- `frame_done` out 1: one-cycle pulse on each frame commit.
- `frame_changed` out 1: one-cycle pulse, coincident with `frame_done`, when the committed frame differs from the previous shadow.
- `frame_count` out CNT_W: number of committed frames; wraps from 2^CNT_W-1 to 0.
- `seq_err` out 1: sticky flag; set on any scan-sequence break and cleared only by `rst`.

## Operation
- Storage:
  - Capture buffer `cap[0..15]`.
  - Shadow buffer `shd[0..15]`, both COLS wide.
  - Expected-row counter `exp` (4 bits).
  - FSM states: HUNT and CAPTURE.
- HUNT:
  - Samples every cycle.
  - If `sel_in`==0: `cap[0]`<=`dot_in`, `exp`<=1, go to CAPTURE.
  - Otherwise stay in HUNT; no error is raised.
- CAPTURE, with `sel_in`==`exp`:
  - `cap[exp]`<=`dot_in`, `exp`<=`exp`+1.
  - If `exp`==15, commit (below); `exp` wraps to 0 and the state stays CAPTURE, so row 0 of the next frame is accepted in the following cycle.
- CAPTURE, with `sel_in`!=`exp`:
  - Set `seq_err`; the partial capture is discarded and no commit occurs.
  - If `sel_in`==0: treat as a fresh row 0 in the same cycle (`cap[0]`<=`dot_in`, `exp`<=1, stay in CAPTURE).
  - Otherwise go to HUNT.
- Commit (same edge as the row-15 sample):
  - `shd[0..14]`<=`cap[0..14]` and `shd[15]`<=`dot_in`.
  - `frame_changed` compares the new 256 bits against the old `shd`; it is 1 if any bit differs.
  - `frame_count`++ (wrapping), `frame_valid`<=1.
- First frame after reset is compared against the all-zero shadow: `frame_changed` is 1 unless that frame is entirely blank.
- Row 0 and row 15 are treated as single-cycle samples: each row is held one clock on the bus, with no dwell checking.
- Reset:
  - Outputs: `rd_data`=0, `frame_valid`=0, `frame_done`=0, `frame_changed`=0, `frame_count`=0, `seq_err`=0.
  - Internal: `cap`/`shd` cleared, `exp`=0, state HUNT.
- Reset mid-frame abandons the capture; the next commit requires a full row 0..15 sequence seen after reset.

## Timing
- Row sample latency: `cap` is written at the edge ending the cycle in which `sel_in`/`dot_in` are presented.
- `frame_done`/`frame_changed` are high for exactly the cycle following the row-15 sample.
- Shadow contents are updated at that same edge.
- Read latency: 1 cycle (`rd_data` at edge N+1 reflects `rd_row` and `shd` as of edge N).
  - A read addressed in the `frame_done` cycle returns the new frame.
  - A read addressed in the row-15 sample cycle returns the old frame.
- `frame_done` minimum spacing is 16 cycles under continuous scan.
- `seq_err` is set at the edge ending the offending sample cycle and holds until `rst`.
- `rst` takes priority over every other event in the same cycle.

## Test plan
- Clean scan:
  - Stimulus: rows 0..15 with `dot_in`=0x1000+row, repeated 3 frames.
  - Required: `frame_done` pulses 16 cycles apart; `frame_count` reaches 3; `frame_valid`=1; `seq_err`=0.
  - Readback: `rd_row`=5 returns 0x1005 one cycle later.
- Change detection:
  - Stimulus: frame A (all rows 0x03C0), A again, then B (row 8 = 0x3FFC, others 0x03C0).
  - Required: `frame_changed`=1, 0, 1 on the three `frame_done` pulses.
- Sequence break:
  - Stimulus: rows 0..6, then `sel_in`=9, then a clean frame.
  - Required: `seq_err` rises after the 9 is sampled and stays 1; no `frame_done` for the broken frame.
  - Required: the clean frame commits with `frame_count` incremented by 1.
- Early restart:
  - Stimulus: rows 0..10, then `sel_in`=0 followed by a full 0..15.
  - Required: `seq_err`=1 and a single commit 16 cycles after the restart, containing the new data only.
- Hunt entry:
  - Stimulus: scan starting at row 7 after reset.
  - Required: no `seq_err`; the first `frame_done` occurs 16 cycles after the first `sel_in`=0.
- Reset and wrap:
  - Stimulus: assert `rst` at row 9.
  - Required: all outputs 0 the next cycle; the next commit needs a full 0..15 sequence.
  - Stimulus: run 256 clean frames.
  - Required: `frame_count` reads 0 with `frame_valid` still 1.
